// File: rtl/simmem_wresp_delay_tracker.sv
// simmem_wresp_delay_tracker
// Delays write responses of the simulated memory controller by a DRAM-like
// latency. Each accepted write address gets a slot with a down-counter loaded
// from a single-bank open-row cost model; once the counter reaches zero and no
// older request with the same ID is still pending, the ID is offered to the
// write-response bank on the release port.
//
// Request layout: waddr_i = {id, addr}, id in the upper IDWidth bits.
//
// Build option: define SIMMEM_ROW_MODEL_EN to enable the row-buffer cost
// model (hit 10 / closed 55 / miss 105). Without it every request costs
// RowHitCost and no open-row state is kept.

module simmem_wresp_delay_tracker #(
   parameter int NumSlots          = 8,
   parameter int CounterWidth      = 8,
   parameter int IDWidth           = 4,
   parameter int AxAddrWidth       = 16,
   parameter int RowBufferLenWidth = 8,
   localparam int ReqWidth         = IDWidth + AxAddrWidth,
   localparam int OccWidth         = $clog2(NumSlots) + 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                waddr_valid_i,
   output logic                waddr_ready_o,
   input  logic [ReqWidth-1:0] waddr_i,
   output logic                release_valid_o,
   output logic [IDWidth-1:0]  release_id_o,
   input  logic                release_ready_i,
   output logic [OccWidth-1:0] occupancy_o
);

   localparam int RowHitCost     = 10;
   localparam int PrechargeCost  = 50;
   localparam int ActivationCost = 45;
   localparam int IdxWidth       = $clog2(NumSlots);
   localparam int RowWidth       = AxAddrWidth - RowBufferLenWidth;

   logic [IDWidth-1:0]      req_id;
   logic [AxAddrWidth-1:0]  req_addr;
   logic [CounterWidth-1:0] req_cost;

   logic [NumSlots-1:0]     valid_q, valid_d;
   logic [IDWidth-1:0]      id_q    [NumSlots];
   logic [IDWidth-1:0]      id_d    [NumSlots];
   logic [CounterWidth-1:0] cnt_q   [NumSlots];
   logic [CounterWidth-1:0] cnt_d   [NumSlots];
   // older_q[j][k] set means slot j was already pending when slot k arrived
   logic [NumSlots-1:0]     older_q [NumSlots];
   logic [NumSlots-1:0]     older_d [NumSlots];

   logic [NumSlots-1:0]     elig;
   logic                    rel_any;
   logic [IdxWidth-1:0]     rel_idx;
   logic [IdxWidth-1:0]     alloc_idx;
   logic                    accept;
   logic                    release_fire;
   logic [OccWidth-1:0]     occ;

   assign req_id   = waddr_i[ReqWidth-1 -: IDWidth];
   assign req_addr = waddr_i[AxAddrWidth-1:0];

`ifdef SIMMEM_ROW_MODEL_EN
   logic [RowWidth-1:0] req_row;
   logic [RowWidth-1:0] open_row_q;
   logic                row_open_q;
   logic                unused_addr_bits;

   assign req_row          = req_addr[AxAddrWidth-1:RowBufferLenWidth];
   assign unused_addr_bits = ^req_addr[RowBufferLenWidth-1:0];

   // Cost of the incoming request against the single open row.
   always_comb begin
      if (!row_open_q) begin
         req_cost = CounterWidth'(ActivationCost + RowHitCost);
      end else if (req_row == open_row_q) begin
         req_cost = CounterWidth'(RowHitCost);
      end else begin
         req_cost = CounterWidth'(PrechargeCost + ActivationCost + RowHitCost);
      end
   end

   // Every accepted access leaves its row open.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         row_open_q <= 1'b0;
         open_row_q <= '0;
      end else if (accept) begin
         row_open_q <= 1'b1;
         open_row_q <= req_row;
      end
   end
`else
   logic unused_addr_bits;

   assign unused_addr_bits = ^req_addr;
   assign req_cost         = CounterWidth'(RowHitCost);
`endif

   // Full only when every slot is valid; a same-cycle release does not help.
   assign waddr_ready_o = ~&valid_q;
   assign accept        = waddr_valid_i && waddr_ready_o;
   assign release_fire  = rel_any && release_ready_i;

   // Lowest-index free slot for allocation.
   always_comb begin
      alloc_idx = '0;
      for (int i = NumSlots - 1; i >= 0; i--) begin
         if (!valid_q[i]) alloc_idx = IdxWidth'(i);
      end
   end

   // A slot is eligible once its counter is spent and no older same-ID slot remains.
   always_comb begin
      for (int k = 0; k < NumSlots; k++) begin
         elig[k] = valid_q[k] && (cnt_q[k] == '0);
         for (int j = 0; j < NumSlots; j++) begin
            if (valid_q[j] && older_q[j][k] && (id_q[j] == id_q[k])) elig[k] = 1'b0;
         end
      end
   end

   // Lowest-index eligible slot drives the release port.
   always_comb begin
      rel_idx = '0;
      for (int i = NumSlots - 1; i >= 0; i--) begin
         if (elig[i]) rel_idx = IdxWidth'(i);
      end
   end

   assign rel_any         = |elig;
   assign release_valid_o = rel_any;
   assign release_id_o    = rel_any ? id_q[rel_idx] : '0;

   // Occupancy is the population count of valid slots.
   always_comb begin
      occ = '0;
      for (int i = 0; i < NumSlots; i++) begin
         occ = occ + OccWidth'(valid_q[i]);
      end
   end

   assign occupancy_o = occ;

   // Next-state: count down, then apply accept, then release (release last so
   // an aging bit set against the departing slot is wiped in the same cycle).
   always_comb begin
      valid_d = valid_q;
      older_d = older_q;
      for (int k = 0; k < NumSlots; k++) begin
         id_d[k]  = id_q[k];
         cnt_d[k] = (valid_q[k] && (cnt_q[k] != '0)) ? cnt_q[k] - CounterWidth'(1) : cnt_q[k];
      end
      if (accept) begin
         valid_d[alloc_idx] = 1'b1;
         id_d[alloc_idx]    = req_id;
         cnt_d[alloc_idx]   = req_cost - CounterWidth'(1);
         for (int j = 0; j < NumSlots; j++) begin
            older_d[j][alloc_idx] = valid_q[j];
         end
         older_d[alloc_idx] = '0;
      end
      if (release_fire) begin
         valid_d[rel_idx] = 1'b0;
         older_d[rel_idx] = '0;
         for (int j = 0; j < NumSlots; j++) begin
            older_d[j][rel_idx] = 1'b0;
         end
      end
   end

   // Slot state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         for (int i = 0; i < NumSlots; i++) begin
            id_q[i]    <= '0;
            cnt_q[i]   <= '0;
            older_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < NumSlots; i++) begin
            id_q[i]    <= id_d[i];
            cnt_q[i]   <= cnt_d[i];
            older_q[i] <= older_d[i];
         end
      end
   end

endmodule

// File: tb/tb_simmem_wresp_delay_tracker.sv
// Bench for simmem_wresp_delay_tracker: a timestamp scoreboard predicts the
// release port and occupancy every cycle, plus directed latency checks.
// Honours SIMMEM_ROW_MODEL_EN for the expected costs.

module tb_simmem_wresp_delay_tracker;

   localparam int N      = 8;
   localparam int C_HIT  = 10;
`ifdef SIMMEM_ROW_MODEL_EN
   localparam int C_CLOSED = 55;
   localparam int C_MISS   = 105;
`else
   localparam int C_CLOSED = 10;
   localparam int C_MISS   = 10;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        waddr_valid = 1'b0;
   logic [19:0] waddr = '0;
   logic        waddr_ready;
   logic        rel_valid;
   logic [3:0]  rel_id;
   logic        rel_ready = 1'b0;
   logic [3:0]  occupancy;

   always #5 clk = ~clk;

   simmem_wresp_delay_tracker dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .waddr_valid_i   (waddr_valid),
      .waddr_ready_o   (waddr_ready),
      .waddr_i         (waddr),
      .release_valid_o (rel_valid),
      .release_id_o    (rel_id),
      .release_ready_i (rel_ready),
      .occupancy_o     (occupancy)
   );

   typedef struct {int id; int slot; int rdy;} ent_t;
   typedef struct {int id; int cyc;} rel_t;

   ent_t pend[$];
   rel_t rel_log[$];
   bit   busy[N];
   int   cyc = 0;
   bit   m_row_open = 0;
   int   m_open_row = 0;
   int   total = 0;
   int   bad = 0;

   task automatic check_val(input string tag, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic int model_cost(input int addr);
      int row;
      row = (addr >> 8) & 255;
`ifdef SIMMEM_ROW_MODEL_EN
      if (!m_row_open) return 55;
      if (row == m_open_row) return 10;
      return 105;
`else
      return 10;
`endif
   endfunction

   function automatic int log_id(input int i);
      if (i < rel_log.size()) return rel_log[i].id;
      return -1;
   endfunction

   function automatic int log_cyc(input int i);
      if (i < rel_log.size()) return rel_log[i].cyc;
      return -1;
   endfunction

   function automatic int rel_at(input int id);
      foreach (rel_log[i]) if (rel_log[i].id == id) return rel_log[i].cyc;
      return -1;
   endfunction

   // One clock: check outputs against the scoreboard, drive, then advance the model.
   task automatic run_cycle(input bit v, input int id, input int addr, input bit rr);
      int  occ, eidx, eid, best, cost, slot;
      bit  ev, el, exp_rdy;
      @(negedge clk);
      occ     = pend.size();
      exp_rdy = (occ < N);
      ev = 0; eid = 0; eidx = 0; best = N;
      for (int i = 0; i < pend.size(); i++) begin
         el = (pend[i].rdy <= cyc);
         for (int j = 0; j < i; j++) if (pend[j].id == pend[i].id) el = 0;
         if (el && pend[i].slot < best) begin
            best = pend[i].slot; eidx = i; ev = 1; eid = pend[i].id;
         end
      end
      check_val("occupancy", occupancy, occ);
      check_val("waddr_ready", waddr_ready, exp_rdy);
      check_val("release_valid", rel_valid, ev);
      check_val("release_id", rel_id, eid);
      waddr_valid = v;
      waddr       = {4'(id), 16'(addr)};
      rel_ready   = rr;
      @(posedge clk);
      if (v && exp_rdy) begin
         cost = model_cost(addr);
         slot = 0;
         for (int s = N - 1; s >= 0; s--) if (!busy[s]) slot = s;
         busy[slot] = 1;
         pend.push_back('{id, slot, cyc + cost});
         m_row_open = 1;
         m_open_row = (addr >> 8) & 255;
      end
      if (ev && rr) begin
         busy[pend[eidx].slot] = 0;
         rel_log.push_back('{pend[eidx].id, cyc});
         pend.delete(eidx);
      end
      cyc++;
   endtask

   task automatic idle(input int n, input bit rr);
      for (int i = 0; i < n; i++) run_cycle(0, 0, 0, rr);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n       = 1'b0;
      waddr_valid = 1'b0;
      rel_ready   = 1'b0;
      #1;
      check_val("rst_release_valid", rel_valid, 0);
      check_val("rst_occupancy", occupancy, 0);
      check_val("rst_waddr_ready", waddr_ready, 1);
      check_val("rst_release_id", rel_id, 0);
      pend.delete();
      rel_log.delete();
      for (int s = 0; s < N; s++) busy[s] = 0;
      m_row_open = 0;
      m_open_row = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int t0, e0, e1, e2;

      // single request, closed row
      do_reset();
      t0 = cyc;
      run_cycle(1, 1, 'h0100, 1);
      idle(60, 1);
      check_val("t1_count", rel_log.size(), 1);
      check_val("t1_id", log_id(0), 1);
      check_val("t1_latency", log_cyc(0) - t0, C_CLOSED);
      #1 check_val("t1_occ_end", occupancy, 0);

      // same-row hit overtakes the first
      do_reset();
      t0 = cyc;
      run_cycle(1, 1, 'h0100, 1);
      run_cycle(1, 2, 'h0120, 1);
      idle(60, 1);
      check_val("t2_id1_cycle", rel_at(1), t0 + C_CLOSED);
      check_val("t2_id2_cycle", rel_at(2), t0 + 1 + C_HIT);

      // row miss
      do_reset();
      t0 = cyc;
      run_cycle(1, 1, 'h0100, 1);
      run_cycle(1, 2, 'h0300, 1);
      idle(110, 1);
      check_val("t3_id1_cycle", rel_at(1), t0 + C_CLOSED);
      check_val("t3_id2_cycle", rel_at(2), t0 + 1 + C_MISS);

      // same-ID ordering
      do_reset();
      t0 = cyc;
      run_cycle(1, 3, 'h0100, 1);
      run_cycle(1, 3, 'h0300, 1);
      run_cycle(1, 3, 'h0310, 1);
      idle(115, 1);
      e0 = t0 + C_CLOSED;
      e1 = (t0 + 1 + C_MISS > e0 + 1) ? t0 + 1 + C_MISS : e0 + 1;
      e2 = (t0 + 2 + C_HIT > e1 + 1) ? t0 + 2 + C_HIT : e1 + 1;
      check_val("t4_count", rel_log.size(), 3);
      check_val("t4_first", log_cyc(0), e0);
      check_val("t4_second", log_cyc(1), e1);
      check_val("t4_third", log_cyc(2), e2);
      check_val("t4_third_id", log_id(2), 3);

      // full
      do_reset();
      for (int i = 0; i < N; i++) run_cycle(1, i, 'h0100, 0);
      #1;
      check_val("t5_full_ready", waddr_ready, 0);
      check_val("t5_full_occ", occupancy, 8);
      run_cycle(1, 9, 'h0200, 0);
      idle(60, 0);
      run_cycle(0, 0, 0, 1);
      #1;
      check_val("t5_ready_after_release", waddr_ready, 1);
      check_val("t5_occ_after_release", occupancy, 7);
      check_val("t5_first_id", log_id(0), 0);
      idle(20, 1);
      check_val("t5_drained", rel_log.size(), 8);

      // simultaneous accept and release
      do_reset();
      t0 = cyc;
      run_cycle(1, 1, 'h0100, 1);
      idle(C_CLOSED - 1, 1);
      run_cycle(1, 2, 'h0100, 1);
      #1;
      check_val("t6_occ_same", occupancy, 1);
      check_val("t6_id1_cycle", log_cyc(0), t0 + C_CLOSED);
      idle(20, 1);
      check_val("t6_id2_cycle", rel_at(2), t0 + C_CLOSED + C_HIT);

      // reset mid-operation
      do_reset();
      run_cycle(1, 4, 'h0100, 0);
      run_cycle(1, 5, 'h0140, 0);
      run_cycle(1, 6, 'h0500, 0);
      idle(17, 0);
      do_reset();
      t0 = cyc;
      run_cycle(1, 5, 'h0100, 1);
      idle(60, 1);
      check_val("t7_count", rel_log.size(), 1);
      check_val("t7_latency", rel_at(5) - t0, C_CLOSED);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
